hilo_muldiv_unit: RTL

Sits in the execute stage, directly downstream of `multiplier`, and owns the architectural HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from execute with a valid/ready handshake. Multiplies are issued to `multiplier` and its 64-bit product is captured one cycle later. Divides run on an internal iterative restoring divider. `busy` stalls the pipeline, and `hi`/`lo` feed MFHI/MFLO.

---
 rtl/hilo_muldiv_unit_pkg.sv | 36 +++
 rtl/hilo_muldiv_unit_divider.sv | 65 ++++++
 rtl/hilo_muldiv_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit and its divider.
package hilo_muldiv_unit_pkg;

  localparam int CPU_DATA_WIDTH = 32;
  localparam int DATA_WIDTH     = CPU_DATA_WIDTH;
  localparam int DIV_ITERATIONS = 32;
  localparam int COUNT_WIDTH    = $clog2(DIV_ITERATIONS);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } MulDivOp;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_RUN  = 2'd2,
    ST_DIV_FIX  = 2'd3
  } MulDivState;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
  } HiLoData;

  // Magnitude of a two's-complement value when treated as signed, else unchanged.
  function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] v,
                                                    input logic is_signed);
    return (is_signed && v[DATA_WIDTH-1]) ? ({DATA_WIDTH{1'b0}} - v) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_divider.sv
// Unsigned iterative restoring divider: one quotient bit per clock after start.
module hilo_muldiv_unit_divider
  import hilo_muldiv_unit_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_active,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_quotient,
  output logic [DATA_WIDTH-1:0] o_remainder
);

  logic                   r_active;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0]  r_rem;
  logic [DATA_WIDTH-1:0]  r_quo;
  logic [DATA_WIDTH-1:0]  r_divisor;

  logic [DATA_WIDTH:0]    w_shift;
  logic [DATA_WIDTH:0]    w_diff;
  logic                   w_ge;
  logic                   w_last;

  // Quotient register doubles as the dividend shifter; its MSB feeds the remainder.
  assign w_shift = {r_rem, r_quo[DATA_WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_divisor});
  assign w_diff  = w_shift - {1'b0, r_divisor};
  assign w_last  = r_active && (r_count == COUNT_WIDTH'(DIV_ITERATIONS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_active  <= 1'b0;
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
    end else if (i_abort) begin
      r_active <= 1'b0;
      r_count  <= '0;
    end else if (i_start) begin
      r_active  <= 1'b1;
      r_count   <= '0;
      r_rem     <= '0;
      r_quo     <= i_dividend;
      r_divisor <= i_divisor;
    end else if (r_active) begin
      r_rem   <= w_ge ? w_diff[DATA_WIDTH-1:0] : w_shift[DATA_WIDTH-1:0];
      r_quo   <= {r_quo[DATA_WIDTH-2:0], w_ge};
      r_count <= r_count + COUNT_WIDTH'(1);
      if (w_last) begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_active    = r_active;
  assign o_done      = w_last;
  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Execute-stage HI/LO owner: captures multiplier products, runs divides, serves MTHI/MTLO.
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [2:0]              i_req_op,
  input  logic [DATA_WIDTH-1:0]   i_req_src1,
  input  logic [DATA_WIDTH-1:0]   i_req_src2,
  input  logic                    i_cancel,
  output logic [DATA_WIDTH-1:0]   o_mul_input1,
  output logic [DATA_WIDTH-1:0]   o_mul_input2,
  output logic                    o_mul_is_signed,
  input  logic [2*DATA_WIDTH-1:0] i_mul_result,
  output logic                    o_busy,
  output logic [DATA_WIDTH-1:0]   o_hi,
  output logic [DATA_WIDTH-1:0]   o_lo
);

  MulDivState            r_state;
  HiLoData               r_hilo;
  logic [DATA_WIDTH-1:0] r_src1;
  logic                  r_div_zero;
  logic                  r_neg_quo;
  logic                  r_neg_rem;

  MulDivOp               w_op;
  logic                  w_accept;
  logic                  w_is_div_signed;
  logic                  w_div_start;
  logic                  w_div_abort;
  logic                  w_div_active;
  logic                  w_div_done;
  logic [DATA_WIDTH-1:0] w_quo;
  logic [DATA_WIDTH-1:0] w_rem;
  logic [DATA_WIDTH-1:0] w_fix_quo;
  logic [DATA_WIDTH-1:0] w_fix_rem;

  assign w_op            = MulDivOp'(i_req_op);
  assign o_req_ready     = (r_state == ST_IDLE) && !i_cancel;
  assign w_accept        = i_req_valid && o_req_ready;
  assign w_is_div_signed = (w_op == OP_DIV);
  assign w_div_start     = w_accept && ((w_op == OP_DIV) || (w_op == OP_DIVU));
  assign w_div_abort     = i_cancel && (r_state != ST_IDLE);

  assign o_mul_input1    = i_req_src1;
  assign o_mul_input2    = i_req_src2;
  assign o_mul_is_signed = (w_op == OP_MULT);

  hilo_muldiv_unit_divider u_divider (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (w_div_start),
    .i_abort     (w_div_abort),
    .i_dividend  (abs_val(i_req_src1, w_is_div_signed)),
    .i_divisor   (abs_val(i_req_src2, w_is_div_signed)),
    .o_active    (w_div_active),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  assign w_fix_quo = r_neg_quo ? ({DATA_WIDTH{1'b0}} - w_quo) : w_quo;
  assign w_fix_rem = r_neg_rem ? ({DATA_WIDTH{1'b0}} - w_rem) : w_rem;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_hilo     <= '0;
      r_src1     <= '0;
      r_div_zero <= 1'b0;
      r_neg_quo  <= 1'b0;
      r_neg_rem  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (w_op)
              OP_MTHI:           r_hilo.hi <= i_req_src1;
              OP_MTLO:           r_hilo.lo <= i_req_src1;
              OP_MULT, OP_MULTU: r_state   <= ST_MUL_WAIT;
              OP_DIV, OP_DIVU: begin
                r_state    <= ST_DIV_RUN;
                r_src1     <= i_req_src1;
                r_div_zero <= (i_req_src2 == '0);
                r_neg_quo  <= w_is_div_signed &&
                              (i_req_src1[DATA_WIDTH-1] ^ i_req_src2[DATA_WIDTH-1]);
                r_neg_rem  <= w_is_div_signed && i_req_src1[DATA_WIDTH-1];
              end
              default: ;
            endcase
          end
        end
        ST_MUL_WAIT: begin
          if (!i_cancel) begin
            r_hilo <= i_mul_result;
          end
          r_state <= ST_IDLE;
        end
        ST_DIV_RUN: begin
          if (i_cancel) begin
            r_state <= ST_IDLE;
          end else if (w_div_done) begin
            r_state <= ST_DIV_FIX;
          end
        end
        ST_DIV_FIX: begin
          // Divide by zero keeps the raw dividend in HI and skips the sign fix.
          if (!i_cancel) begin
            if (r_div_zero) begin
              r_hilo.hi <= r_src1;
              r_hilo.lo <= '1;
            end else begin
              r_hilo.hi <= w_fix_rem;
              r_hilo.lo <= w_fix_quo;
            end
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != ST_IDLE);
  assign o_hi   = r_hilo.hi;
  assign o_lo   = r_hilo.lo;

endmodule
